// File: rtl/acc_mem_responder.sv
// Single-port word memory responder for the accumulator CPU: accepts one read/write, waits LATENCY cycles, pulses rdy.
// Latency LATENCY+1 cycles to rdy; no new request is taken while busy, so one access per LATENCY+3 cycles.
// Optional per-word parity with error injection is built when ACC_MEM_PARITY_EN is defined.
module acc_mem_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              par_inject,
    output logic [DATA_W-1:0] rdata,
    output logic              rdy,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              accept;
    logic              access;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_en) begin
                    accept    = 1'b1;
                    cnt_nxt   = 4'(LATENCY);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request fields are sampled only on acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            we_q    <= mem_we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Storage is deliberately unreset so contents survive rst.
    always_ff @(posedge clk) begin
        if (access && we_q && !rst) begin
            mem[addr_q] <= wdata_q;
        end
    end

`ifdef ACC_MEM_PARITY_EN
    logic              inj_q;
    logic              par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            inj_q <= par_inject;
        end
    end

    always_ff @(posedge clk) begin
        if (access && we_q && !rst) begin
            par_mem[addr_q] <= (^wdata_q) ^ inj_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (access) begin
            err <= we_q ? 1'b0 : ((^mem[addr_q]) != par_mem[addr_q]);
        end
    end
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;

    always_ff @(posedge clk) begin
        err <= 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy   <= 1'b0;
            rdata <= '0;
        end else begin
            rdy <= access;
            if (access && !we_q) begin
                rdata <= mem[addr_q];
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/acc_mem_responder.md
# acc_mem_responder

- Memory-side responder for the accumulator CPU's data/instruction memory port.
- Accepts single-word read or write requests driven by the CPU control unit's `mem_en`/`mem_we` strobes.
- Performs each access after a configurable number of wait cycles, then returns read data with a one-cycle `rdy` pulse.
- Sits between the control/datapath and the storage array; it lets the controller be exercised against realistic, non-zero memory latency.

## Interface

Parameters:
- DATA_W, 8, data word width.
- ADDR_W, 5, address width; array depth is 2**ADDR_W words.
- LATENCY, 2, wait cycles inserted before the access; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_en  in  1  request strobe; sampled only in IDLE.
- mem_we  in  1  1 = write, 0 = read; captured with mem_en.
- addr  in  ADDR_W  word address; captured with mem_en.
- wdata  in  DATA_W  write data; captured with mem_en.
- par_inject  in  1  test input that corrupts stored parity on a write; captured with mem_en; ignored without parity.
- rdata  out  DATA_W  read data; registered; valid while rdy=1, held otherwise.
- rdy  out  1  one-cycle completion pulse for reads and writes.
- busy  out  1  high whenever state != IDLE.
- err  out  1  parity error flag; qualified by rdy.

## Operation

- FSM states: IDLE, WAIT, RESP. The state register and 4-bit counter cnt are the only control state.
- IDLE:
  - If mem_en=1 at an edge: capture mem_we, addr, wdata and par_inject; load cnt<=LATENCY; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt!=0: cnt<=cnt-1; stay in WAIT.
  - If cnt==0, perform the access:
    - Write: mem[addr]<=wdata; rdata unchanged; err<=0.
    - Read: rdata<=mem[addr]; err per Configuration.
  - In both cases set rdy<=1 and go to RESP.
- RESP:
  - rdy<=0; go to IDLE.
  - mem_en is ignored in RESP. A request is never accepted in the same cycle that rdy is high.
- Inputs are captured only at acceptance. Changes to addr, wdata or mem_we while busy have no effect.
- The storage array is not reset. Reading an unwritten location returns undefined data; err is undefined for that read.

Reset:
- rst=1 forces state=IDLE, cnt=0, rdy=0, rdata=0, err=0; busy=0 follows from state.
- Reset takes priority over every transition.
- Reset asserted in WAIT before the access edge aborts the request: no write occurs and no rdy is issued.
- The array keeps its contents through reset.

## Timing

- Request accepted at edge N → access and rdy rise at edge N+1+LATENCY → rdy falls at edge N+2+LATENCY.
- Earliest next acceptance is edge N+3+LATENCY, giving a throughput of one access per LATENCY+3 cycles.
- LATENCY=0: access at edge N+1; rdy is high for the cycle following edge N+1.
- busy rises at edge N and falls at edge N+2+LATENCY.
- rdata and err change only at access edges or on reset.
- Read-after-write to the same address returns the new data, because the write completes before the next request can be accepted.

## Configuration

- Macro: ACC_MEM_PARITY_EN.
- Defined:
  - Each word stores one extra parity bit.
  - On a write, the stored parity is (^wdata)^par_inject.
  - On a read, err<=(^mem_data)!=stored_parity, presented together with rdy.
- Not defined:
  - No parity storage is built.
  - err is held at 0.
  - par_inject is unused.

## Test plan

- Reset: drive rst=1 for 2 cycles with mem_en=1 → rdy=0, busy=0, rdata=0x00, err=0; no write occurs.
- LATENCY=2: write 0xA5 to address 3 with request at edge N → rdy high only in the cycle after edge N+3. Then read address 3 → rdata=0xA5 with rdy, err=0.
- LATENCY=0: read back 0x3C previously written to address 31 (address wrap boundary) → rdy in the cycle after edge N+1; busy low after edge N+2.
- mem_en held high continuously with LATENCY=1, writing alternating addresses 0 and 1 → accepts occur every 4 cycles, rdy pulses are never adjacent, and mem_en during RESP is ignored.
- Reset mid-operation: write 0xFF to address 5 over existing 0x11, with rst pulsed during WAIT → no rdy is issued; a subsequent read of address 5 returns 0x11.
- With ACC_MEM_PARITY_EN: write 0x0F with par_inject=1, then read it → rdy=1 with err=1. Rewrite with par_inject=0, then read → err=0.
